// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the two-requester SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Requester index; also the payload of each read-tag FIFO entry.
  typedef logic req_id_t;

  localparam int DEF_ADDRW    = 26;
  localparam int DEF_DATAW    = 32;
  localparam int DEF_RD_DEPTH = 8;

endpackage

// File: rtl/rd_tag_fifo.sv
// Records which requester issued each outstanding read so returns can be routed in order.
module rd_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int  DEPTH = DEF_RD_DEPTH,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  req_id_t       push_id,
  input  logic          pop,
  output req_id_t       head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sdram_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master between two requesters,
// with in-order routing of pipelined read returns.
module sdram_master_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = DEF_ADDRW,
  parameter int DATAWIDTH           = DEF_DATAW,
  parameter int RD_DEPTH            = DEF_RD_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MASTER_ADDRESSWIDTH-1:0] r0_address,
  input  logic [DATAWIDTH-1:0]           r0_writedata,
  input  logic                           r0_write,
  input  logic                           r0_read,
  output logic                           r0_waitrequest,
  output logic [DATAWIDTH-1:0]           r0_readdata,
  output logic                           r0_readdatavalid,
  input  logic [MASTER_ADDRESSWIDTH-1:0] r1_address,
  input  logic [DATAWIDTH-1:0]           r1_writedata,
  input  logic                           r1_write,
  input  logic                           r1_read,
  output logic                           r1_waitrequest,
  output logic [DATAWIDTH-1:0]           r1_readdata,
  output logic                           r1_readdatavalid,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           busy,
  output logic                           err_unexpected_rdv
);

  localparam int CW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;

  arb_state_t state, state_nxt;
  req_id_t    prio, prio_nxt;   // requester favoured on a tie
  req_id_t    owner, tag_head;
  logic       push, tag_full, tag_empty, rdv_hit;
  logic       own_read, own_write, own_wait;
  logic [MASTER_ADDRESSWIDTH-1:0] own_address;
  logic [DATAWIDTH-1:0]           own_writedata;
  logic [CW:0]                    tag_count;

  assign owner         = (state == OWN1);
  assign own_read      = owner ? r1_read      : r0_read;
  assign own_write     = owner ? r1_write     : r0_write;
  assign own_address   = owner ? r1_address   : r0_address;
  assign own_writedata = owner ? r1_writedata : r0_writedata;
  // A full tag FIFO stalls reads only; the stall ignores any same-cycle return.
  assign own_wait      = master_waitrequest | (own_read & tag_full);

  always_comb begin
    state_nxt        = state;
    prio_nxt         = prio;
    push             = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    master_read      = 1'b0;
    master_write     = 1'b0;
    r0_waitrequest   = 1'b1;
    r1_waitrequest   = 1'b1;
    case (state)
      IDLE: begin
        if ((r0_read | r0_write) && (!(r1_read | r1_write) || prio == 1'b0))
          state_nxt = OWN0;
        else if (r1_read | r1_write)
          state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        master_address   = own_address;
        master_writedata = own_writedata;
        master_write     = own_write;
        master_read      = own_read & ~tag_full;
        if (owner) r1_waitrequest = own_wait;
        else       r0_waitrequest = own_wait;
        if ((master_read | master_write) && !master_waitrequest) begin
          state_nxt = IDLE;
          prio_nxt  = ~owner;
          push      = master_read;
        end else if (!own_read && !own_write) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      prio               <= 1'b0;
      err_unexpected_rdv <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      if (master_readdatavalid && tag_empty) err_unexpected_rdv <= 1'b1;
    end
  end

  rd_tag_fifo #(.DEPTH(RD_DEPTH)) u_tags (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_id (owner),
    .pop     (master_readdatavalid),
    .head    (tag_head),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  assign rdv_hit          = master_readdatavalid & ~tag_empty;
  assign r0_readdatavalid = rdv_hit & (tag_head == 1'b0);
  assign r1_readdatavalid = rdv_hit & (tag_head == 1'b1);
  assign r0_readdata      = master_readdata;
  assign r1_readdata      = master_readdata;
  assign busy             = (state != IDLE) | ~tag_empty;

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Directed vector table plus hand sequences for tag-FIFO backpressure and reset corners.
module tb_sdram_master_arbiter;

  localparam logic [31:0] D0 = 32'h00FF0000;
  localparam logic [31:0] D1 = 32'h11110000;
  localparam logic [25:0] A1 = 26'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] r0_address, r1_address, master_address;
  logic [31:0] r0_writedata, r1_writedata, master_writedata;
  logic        r0_write, r0_read, r1_write, r1_read;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata, master_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic        master_write, master_read, master_readdatavalid, master_waitrequest;
  logic        busy, err_unexpected_rdv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_master_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_writedata(r0_writedata), .r0_write(r0_write),
    .r0_read(r0_read), .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_writedata(r1_writedata), .r1_write(r1_write),
    .r1_read(r1_read), .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_read(master_read),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .master_waitrequest(master_waitrequest),
    .busy(busy), .err_unexpected_rdv(err_unexpected_rdv)
  );

  typedef struct {
    logic [3:0]  cmd;    // {r0_read, r0_write, r1_read, r1_write}
    logic [25:0] r0a;
    logic        mwait;
    logic        rdv;
    logic [31:0] rdata;
    logic [1:0]  e_ms;   // {master_read, master_write}
    logic [25:0] e_addr;
    logic [31:0] e_wdata;
    logic [1:0]  e_w;    // {r0_waitrequest, r1_waitrequest}
    logic [1:0]  e_v;    // {r0_readdatavalid, r1_readdatavalid}
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] cmd, input logic [25:0] r0a, input logic mwait,
                     input logic rdv, input logic [31:0] rdata, input logic [1:0] ms,
                     input logic [25:0] ea, input logic [31:0] ewd, input logic [1:0] ew,
                     input logic [1:0] ev, input logic eb);
    vec_t v;
    v.cmd = cmd; v.r0a = r0a; v.mwait = mwait; v.rdv = rdv; v.rdata = rdata;
    v.e_ms = ms; v.e_addr = ea; v.e_wdata = ewd; v.e_w = ew; v.e_v = ev; v.e_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {r0_read, r0_write, r1_read, r1_write} = 4'b0;
    r0_address = '0; r1_address = A1; r0_writedata = D0; r1_writedata = D1;
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_unexpected_rdv, 1'b0);
    chk("rst_strobes", {master_read, master_write}, 2'b00);
    chk("rst_wait", {r0_waitrequest, r1_waitrequest}, 2'b11);
    tick(); tick();
    reset = 1'b0;

    // single r0 write
    add(4'b0100, 26'h0,  0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    add(4'b0100, 26'h0,  0, 0, 0, 2'b01, 26'h0,  D0, 2'b01, 2'b00, 1);
    add(4'b0000, 26'h0,  0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    // both writing continuously: alternate, IDLE between accepts
    add(4'b0101, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    add(4'b0101, 26'h10, 0, 0, 0, 2'b01, A1,     D1, 2'b10, 2'b00, 1);
    add(4'b0101, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    add(4'b0101, 26'h10, 0, 0, 0, 2'b01, 26'h10, D0, 2'b01, 2'b00, 1);
    add(4'b0101, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    add(4'b0101, 26'h10, 0, 0, 0, 2'b01, A1,     D1, 2'b10, 2'b00, 1);
    // two reads, returns routed in issue order
    add(4'b1010, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    add(4'b1010, 26'h10, 0, 0, 0, 2'b10, 26'h10, D0, 2'b01, 2'b00, 1);
    add(4'b0010, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 1);
    add(4'b0010, 26'h10, 0, 0, 0, 2'b10, A1,     D1, 2'b10, 2'b00, 1);
    add(4'b0000, 26'h10, 0, 1, 32'hAAAA0000, 2'b00, 26'h0, 0, 2'b11, 2'b10, 1);
    add(4'b0000, 26'h10, 0, 1, 32'hBBBB0000, 2'b00, 26'h0, 0, 2'b11, 2'b01, 1);
    add(4'b0000, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    // r1 write stalled 5 cycles by SDRAM, r0 blocked meanwhile
    add(4'b0001, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    for (int k = 0; k < 5; k++)
      add(4'b0101, 26'h10, 1, 0, 0, 2'b01, A1,   D1, 2'b11, 2'b00, 1);
    add(4'b0101, 26'h10, 0, 0, 0, 2'b01, A1,     D1, 2'b10, 2'b00, 1);
    add(4'b0100, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);
    add(4'b0100, 26'h10, 0, 0, 0, 2'b01, 26'h10, D0, 2'b01, 2'b00, 1);
    add(4'b0000, 26'h10, 0, 0, 0, 2'b00, 26'h0,  0,  2'b11, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      {r0_read, r0_write, r1_read, r1_write} = vecs[i].cmd;
      r0_address = vecs[i].r0a;
      master_waitrequest = vecs[i].mwait;
      master_readdatavalid = vecs[i].rdv;
      master_readdata = vecs[i].rdata;
      #2;
      chk($sformatf("v%0d_strobes", i), {master_read, master_write}, vecs[i].e_ms);
      chk($sformatf("v%0d_addr", i), master_address, vecs[i].e_addr);
      chk($sformatf("v%0d_wdata", i), master_writedata, vecs[i].e_wdata);
      chk($sformatf("v%0d_wait", i), {r0_waitrequest, r1_waitrequest}, vecs[i].e_w);
      chk($sformatf("v%0d_rdv", i), {r0_readdatavalid, r1_readdatavalid}, vecs[i].e_v);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_rdata", i), {r0_readdata, r1_readdata}, {vecs[i].rdata, vecs[i].rdata});
      tick();
    end

    // r1 issues reads until the tag FIFO fills; ninth held until one return
    {r0_read, r0_write, r1_read, r1_write} = 4'b0010;
    master_readdatavalid = 1'b0;
    master_readdata = 32'h5555AAAA;
    for (int k = 0; k < 8; k++) begin
      tick();
      #2;
      chk($sformatf("fill%0d_mread", k), master_read, 1'b1);
      chk($sformatf("fill%0d_wait", k), r1_waitrequest, 1'b0);
      tick();
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      #2;
      chk($sformatf("full%0d_mread", k), master_read, 1'b0);
      chk($sformatf("full%0d_wait", k), r1_waitrequest, 1'b1);
      tick();
    end
    master_readdatavalid = 1'b1;
    #2;
    chk("full_pop_mread", master_read, 1'b0);
    chk("full_pop_wait", r1_waitrequest, 1'b1);
    chk("full_pop_rdv", {r0_readdatavalid, r1_readdatavalid}, 2'b01);
    tick();
    master_readdatavalid = 1'b0;
    #2;
    chk("ninth_mread", master_read, 1'b1);
    chk("ninth_wait", r1_waitrequest, 1'b0);
    tick();
    r1_read = 1'b0;
    #2;
    chk("outstanding_busy", busy, 1'b1);

    // reset with reads in flight, then a stray return
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_strobes", {master_read, master_write}, 2'b00);
    tick();
    reset = 1'b0;
    master_readdatavalid = 1'b1;
    #2;
    chk("stray_rdv", {r0_readdatavalid, r1_readdatavalid}, 2'b00);
    chk("stray_err_pre", err_unexpected_rdv, 1'b0);
    tick();
    master_readdatavalid = 1'b0;
    #2;
    chk("stray_err", err_unexpected_rdv, 1'b1);
    tick(); tick();
    chk("stray_err_sticky", err_unexpected_rdv, 1'b1);
    reset = 1'b1;
    #1;
    chk("err_cleared", err_unexpected_rdv, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
